pipeline_hazard_controller: RTL

Sequencing controller for the five-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM). Issues per-cycle write-enable, hold and flush controls so that load-use hazards stall, taken branches resolved in MEM squash younger instructions, and multi-cycle floating-point operations hold EX until complete. Sits beside the pipeline registers in the top level. Consumes control/address bits already carried by ID/EX and EX/MEM; drives the PC and register enables.

---
 rtl/pipeline_hazard_controller_pkg.sv | 18 +
 rtl/pipeline_hazard_controller_load_use_detect.sv | 31 +++
 rtl/pipeline_hazard_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t    : controller FSM states (RUN, FP_WAIT)
//   REG_ADDR_W : register address width (0-31 integer, 32-63 FP)
//   FP_LAT_W   : width of the FP latency field carried in ID/EX
//   REG_ZERO   : hard-wired zero register; never a real destination
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        FP_WAIT = 1'b1
    } state_t;

    localparam int REG_ADDR_W = 6;
    localparam int FP_LAT_W   = 4;

    localparam logic [5:0] REG_ZERO = 6'd0;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Load-use hazard comparator.
// Flags when the instruction in ID reads a register that the load currently
// in ID/EX is about to write. r0 never hazards; FP register 32 (f0) does.
// Ports:
//   id_rs, id_rt          : source addresses of the ID instruction
//   id_uses_rt            : ID instruction actually reads rt
//   id_ex_mem_read        : ID/EX instruction is a load
//   id_ex_write_address   : ID/EX destination address
//   hazard                : one-cycle stall required
module load_use_detect #(
    parameter int REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_write_address,
    output logic                  hazard
);
    import pipeline_ctrl_pkg::*;

    logic dest_real;
    logic rs_match;
    logic rt_match;

    assign dest_real = (id_ex_write_address != REG_ADDR_W'(REG_ZERO));
    assign rs_match  = (id_rs == id_ex_write_address);
    assign rt_match  = id_uses_rt && (id_rt == id_ex_write_address);
    assign hazard    = id_ex_mem_read && dest_real && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller for the five-stage MIPS pipeline.
// Drives PC / IF/ID / ID/EX / EX/MEM enables so that load-use hazards stall
// one cycle, taken branches resolved in MEM squash the younger instructions,
// and multi-cycle FP ops hold EX for their full latency.
// Ports:
//   clk, reset (sync, active-low)
//   id_rs, id_rt, id_uses_rt            : ID instruction sources
//   id_ex_mem_read, id_ex_write_address : ID/EX load info
//   id_ex_is_fp, id_ex_fp_latency       : ID/EX multi-cycle FP op info
//   ex_mem_branch_taken                 : taken branch in EX/MEM
//   pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
//   ex_mem_bubble                       : pipeline register controls
//   fpu_start, fpu_busy                 : FPU handshake
//   stall_cycles                        : saturating count of stalled cycles
module pipeline_hazard_controller #(
    parameter int REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W,
    parameter int FP_LAT_W   = pipeline_ctrl_pkg::FP_LAT_W,
    parameter int PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_write_address,
    input  logic                  id_ex_is_fp,
    input  logic [FP_LAT_W-1:0]   id_ex_fp_latency,
    input  logic                  ex_mem_branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  fpu_start,
    output logic                  fpu_busy,
    output logic [PERF_W-1:0]     stall_cycles
);
    import pipeline_ctrl_pkg::*;

    state_t              state;
    state_t              state_nxt;
    logic [FP_LAT_W-1:0] cnt;
    logic [FP_LAT_W-1:0] cnt_nxt;
    logic                load_use;
    logic                fp_issue;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs               (id_rs),
        .id_rt               (id_rt),
        .id_uses_rt          (id_uses_rt),
        .id_ex_mem_read      (id_ex_mem_read),
        .id_ex_write_address (id_ex_write_address),
        .hazard              (load_use)
    );

    // Latencies of 0 or 1 behave as ordinary single-cycle ops.
    assign fp_issue = id_ex_is_fp && (id_ex_fp_latency >= FP_LAT_W'(2));

    // State register, FP countdown and stall counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= RUN;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pc_write) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                // A taken branch squashes the FP op before it can issue.
                if (!ex_mem_branch_taken && fp_issue) begin
                    state_nxt = FP_WAIT;
                    cnt_nxt   = id_ex_fp_latency - FP_LAT_W'(1);
                end
            end
            FP_WAIT: begin
                if (cnt > FP_LAT_W'(1)) begin
                    cnt_nxt = cnt - FP_LAT_W'(1);
                end else begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        fpu_start     = 1'b0;
        fpu_busy      = 1'b0;
        if (!reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_write   = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (state == FP_WAIT) begin
            // Branch and load-use are ignored here: EX/MEM only holds bubbles.
            fpu_busy = 1'b1;
            if (cnt > FP_LAT_W'(1)) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_bubble = 1'b1;
            end
        end else if (ex_mem_branch_taken) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (fp_issue) begin
            fpu_start     = 1'b1;
            fpu_busy      = 1'b1;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
        end else if (load_use) begin
            // ID/EX still loads, but it loads a bubble.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

endmodule
